// File: rtl/signal_field_ctrl_if.sv
// Handshake/result bundle between the preamble/demod front end and the SIGNAL-field controller.
// master = bit source and config consumer, slave = signal_field_ctrl.
interface signal_field_ctrl_if #(
    parameter int LEN_W  = 12,
    parameter int NSYM_W = 11,
    parameter int NPAD_W = 8
);
    logic              start;
    logic              data_in;
    logic              bit_valid;
    logic              busy;
    logic              cfg_valid;
    logic              cfg_err;
    logic [2:0]        err_code;
    logic [3:0]        rate;
    logic [LEN_W-1:0]  length;
    logic [7:0]        n_dbps;
    logic [NSYM_W-1:0] n_sym;
    logic [NPAD_W-1:0] n_pad;

    modport master (
        output start, data_in, bit_valid,
        input  busy, cfg_valid, cfg_err, err_code, rate, length, n_dbps, n_sym, n_pad
    );

    modport slave (
        input  start, data_in, bit_valid,
        output busy, cfg_valid, cfg_err, err_code, rate, length, n_dbps, n_sym, n_pad
    );
endinterface

// File: rtl/signal_field_ctrl.sv
// 802.11a SIGNAL-field capture, validation and N_DBPS/N_SYM/N_PAD derivation.
// Optional parity checking is enabled by defining SIGNAL_PARITY_CHECK_EN.
module signal_field_ctrl #(
    parameter int LEN_W  = 12,
    parameter int NSYM_W = 11,
    parameter int NPAD_W = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    signal_field_ctrl_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_CHECK, S_CALC, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [23:0]       field_q;
    logic [4:0]        bit_cnt_q;
    logic [15:0]       acc_q;
    logic [3:0]        rate_q;
    logic [LEN_W-1:0]  length_q;
    logic [7:0]        n_dbps_q;
    logic [NSYM_W-1:0] n_sym_q;
    logic [NPAD_W-1:0] n_pad_q;
    logic              cfg_err_q;
    logic [2:0]        err_code_q;

    logic [7:0]  dbps_lut;
    logic        rate_bad, parity_bad, format_bad;
    logic [2:0]  err_vec;
    logic [15:0] total_w, acc_sum;
    logic        calc_done, last_bit;

    always_comb begin
        dbps_lut = 8'd0;
        case (field_q[23:20])
            4'b1101: dbps_lut = 8'd24;
            4'b1111: dbps_lut = 8'd36;
            4'b0101: dbps_lut = 8'd48;
            4'b0111: dbps_lut = 8'd72;
            4'b1001: dbps_lut = 8'd96;
            4'b1011: dbps_lut = 8'd144;
            4'b0001: dbps_lut = 8'd192;
            4'b0011: dbps_lut = 8'd216;
            default: dbps_lut = 8'd0;
        endcase
    end

    assign rate_bad = (dbps_lut == 8'd0);
`ifdef SIGNAL_PARITY_CHECK_EN
    assign parity_bad = ^field_q[23:6];
`else
    assign parity_bad = 1'b0;
`endif
    assign format_bad = field_q[19] | (|field_q[5:0]) | (field_q[18:7] == 12'd0);
    assign err_vec    = {format_bad, parity_bad, rate_bad};

    // CALC works from the registered header so the field register is free after CHECK.
    assign total_w   = 16'd22 + (16'(length_q) << 3);
    assign acc_sum   = acc_q + {8'd0, n_dbps_q};
    assign calc_done = (acc_sum >= total_w);
    assign last_bit  = bus.bit_valid && (bit_cnt_q == 5'd23);

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.start) begin
            state_d = S_SHIFT;
        end else begin
            case (state_q)
                S_SHIFT: if (last_bit) state_d = S_CHECK;
                S_CHECK: state_d = (|err_vec) ? S_DONE : S_CALC;
                S_CALC:  if (calc_done) state_d = S_DONE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        bus.busy      = (state_q == S_SHIFT) || (state_q == S_CHECK) || (state_q == S_CALC);
        bus.cfg_valid = (state_q == S_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || bus.start) begin
            field_q    <= '0;
            bit_cnt_q  <= '0;
            acc_q      <= '0;
            rate_q     <= '0;
            length_q   <= '0;
            n_dbps_q   <= '0;
            n_sym_q    <= '0;
            n_pad_q    <= '0;
            cfg_err_q  <= 1'b0;
            err_code_q <= '0;
        end else begin
            case (state_q)
                S_SHIFT: begin
                    if (bus.bit_valid) begin
                        field_q   <= {field_q[22:0], bus.data_in};
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                    end
                end
                S_CHECK: begin
                    rate_q     <= field_q[23:20];
                    length_q   <= LEN_W'(field_q[18:7]);
                    n_dbps_q   <= dbps_lut;
                    cfg_err_q  <= |err_vec;
                    err_code_q <= err_vec;
                end
                S_CALC: begin
                    acc_q   <= acc_sum;
                    n_sym_q <= n_sym_q + NSYM_W'(1);
                    if (calc_done) n_pad_q <= NPAD_W'(acc_sum - total_w);
                end
                default: ;
            endcase
        end
    end

    assign bus.cfg_err  = cfg_err_q;
    assign bus.err_code = err_code_q;
    assign bus.rate     = rate_q;
    assign bus.length   = length_q;
    assign bus.n_dbps   = n_dbps_q;
    assign bus.n_sym    = n_sym_q;
    assign bus.n_pad    = n_pad_q;
endmodule

// File: tb/tb_signal_field_ctrl.sv
// Directed bench for signal_field_ctrl: a header-level model predicts results and timing,
// checked every cycle, plus literal expectations for the documented cases.
module tb_signal_field_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    signal_field_ctrl_if #(.LEN_W(12), .NSYM_W(11), .NPAD_W(8)) bus ();

    signal_field_ctrl #(.LEN_W(12), .NSYM_W(11), .NPAD_W(8)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    typedef struct {
        int   rate;
        int   len;
        int   dbps;
        int   nsym;
        int   npad;
        int   err;
        int   code;
        int   lat;
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   c24 = 0;
    int   exp_at = 0;
    bit   armed = 1'b0;
    exp_t exp_r;

    localparam int NEVER = 32'h7fff_ffff;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Header-level reference: table lookup, ceiling division and a bit count for parity.
    function automatic exp_t model(input logic [23:0] f);
        exp_t e;
        int   ones, total;
        logic [3:0] r;
        r = f[23:20];
        e.rate = int'(r);
        e.len  = int'(f[18:7]);
        case (r)
            4'b1101: e.dbps = 24;
            4'b1111: e.dbps = 36;
            4'b0101: e.dbps = 48;
            4'b0111: e.dbps = 72;
            4'b1001: e.dbps = 96;
            4'b1011: e.dbps = 144;
            4'b0001: e.dbps = 192;
            4'b0011: e.dbps = 216;
            default: e.dbps = 0;
        endcase
        ones = 0;
        for (int k = 6; k < 24; k++) ones += int'(f[k]);
        e.code = (e.dbps == 0) ? 1 : 0;
`ifdef SIGNAL_PARITY_CHECK_EN
        if (ones % 2 != 0) e.code += 2;
`endif
        if (f[19] || (f[5:0] != 6'd0) || (e.len == 0)) e.code += 4;
        e.err = (e.code != 0) ? 1 : 0;
        if (e.err != 0) begin
            e.nsym = 0;
            e.npad = 0;
            e.lat  = 1;
        end else begin
            total  = 22 + 8 * e.len;
            e.nsym = (total + e.dbps - 1) / e.dbps;
            e.npad = e.nsym * e.dbps - total;
            e.lat  = e.nsym + 1;
        end
        return e;
    endfunction

    function automatic logic [23:0] make_field(input logic [3:0] r, input logic [11:0] len,
                                               input logic res, input logic [5:0] tail,
                                               input logic flip);
        logic [23:0] f;
        f = {r, res, len, 1'b0, tail};
        f[6] = (^f[23:7]) ^ flip;
        return f;
    endfunction

    task automatic compare_cycle();
        bit v;
        if (!armed) return;
        v = (cyc >= exp_at);
        chk("cfg_valid", int'(bus.cfg_valid), int'(v));
        chk("busy", int'(bus.busy), int'(!v));
        if (v) begin
            chk("cfg_err", int'(bus.cfg_err), exp_r.err);
            chk("err_code", int'(bus.err_code), exp_r.code);
            chk("rate", int'(bus.rate), exp_r.rate);
            chk("length", int'(bus.length), exp_r.len);
            chk("n_dbps", int'(bus.n_dbps), exp_r.dbps);
            chk("n_sym", int'(bus.n_sym), exp_r.nsym);
            chk("n_pad", int'(bus.n_pad), exp_r.npad);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        compare_cycle();
    endtask

    // Sends nbits of the field MSB-first; a 3-cycle bit_valid gap is inserted before bit gap_at.
    task automatic send_field(input logic [23:0] f, input int gap_at, input int nbits);
        exp_r  = model(f);
        armed  = 1'b1;
        exp_at = NEVER;
        bus.start     = 1'b1;
        bus.bit_valid = 1'b1;
        bus.data_in   = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (i == gap_at) begin
                repeat (3) begin
                    bus.bit_valid = 1'b0;
                    bus.data_in   = 1'($urandom);
                    tick();
                end
            end
            bus.data_in   = f[23-i];
            bus.bit_valid = 1'b1;
            tick();
        end
        if (nbits == 24) begin
            c24    = cyc;
            exp_at = cyc + exp_r.lat;
        end
        bus.bit_valid = 1'b0;
    endtask

    // Waits for cfg_valid with junk on the bit inputs, then holds a few cycles.
    task automatic wait_done(output int lat);
        int n = 0;
        while (!bus.cfg_valid && n < 400) begin
            bus.bit_valid = 1'b1;
            bus.data_in   = 1'($urandom);
            tick();
            n++;
        end
        if (!bus.cfg_valid) chk("cfg_valid_timeout", 0, 1);
        lat = cyc - c24;
        bus.bit_valid = 1'b0;
        repeat (3) tick();
    endtask

    int lat;
    int g_sym, g_pad, g_err;
    exp_t m;

    initial begin
        bus.start     = 1'b0;
        bus.data_in   = 1'b0;
        bus.bit_valid = 1'b0;
        repeat (3) tick();
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_cfg_valid", int'(bus.cfg_valid), 0);
        chk("rst_n_sym", int'(bus.n_sym), 0);
        chk("rst_rate", int'(bus.rate), 0);
        rst = 1'b0;
        tick();

        m = model(make_field(4'b1101, 12'd100, 1'b0, 6'd0, 1'b0));
        chk("model_c1_nsym", m.nsym, 35);
        chk("model_c1_npad", m.npad, 18);

        // case 1
        send_field(make_field(4'b1101, 12'd100, 1'b0, 6'd0, 1'b0), -1, 24);
        wait_done(lat);
        chk("c1_latency", lat, 36);
        chk("c1_n_dbps", int'(bus.n_dbps), 24);
        chk("c1_n_sym", int'(bus.n_sym), 35);
        chk("c1_n_pad", int'(bus.n_pad), 18);
        chk("c1_cfg_err", int'(bus.cfg_err), 0);

        // case 2
        send_field(make_field(4'b0011, 12'd4095, 1'b0, 6'd0, 1'b0), -1, 24);
        wait_done(lat);
        chk("c2_n_dbps", int'(bus.n_dbps), 216);
        chk("c2_n_sym", int'(bus.n_sym), 152);
        chk("c2_n_pad", int'(bus.n_pad), 50);
        chk("c2_cfg_err", int'(bus.cfg_err), 0);

        // case 3: parity bit flipped
        send_field(make_field(4'b1101, 12'd100, 1'b0, 6'd0, 1'b1), -1, 24);
        wait_done(lat);
`ifdef SIGNAL_PARITY_CHECK_EN
        chk("c3_cfg_err", int'(bus.cfg_err), 1);
        chk("c3_err_code", int'(bus.err_code), 2);
`else
        chk("c3_cfg_err", int'(bus.cfg_err), 0);
        chk("c3_n_pad", int'(bus.n_pad), 18);
`endif

        // case 4: illegal rate
        send_field(make_field(4'b0000, 12'd10, 1'b0, 6'd0, 1'b0), -1, 24);
        wait_done(lat);
        chk("c4_latency", lat, 1);
        chk("c4_err_code0", int'(bus.err_code[0]), 1);
        chk("c4_n_sym", int'(bus.n_sym), 0);
        chk("c4_length", int'(bus.length), 10);

        // case 5: format errors, then gap insensitivity
        send_field(make_field(4'b0101, 12'd50, 1'b0, 6'b000001, 1'b0), -1, 24);
        wait_done(lat);
        chk("c5_tail_err", int'(bus.err_code[2]), 1);
        send_field(make_field(4'b1011, 12'd0, 1'b0, 6'd0, 1'b0), 7, 24);
        wait_done(lat);
        chk("c5_len0_err", int'(bus.err_code[2]), 1);
        send_field(make_field(4'b1001, 12'd0, 1'b1, 6'd0, 1'b0), 20, 24);
        wait_done(lat);
        chk("c5_res_err", int'(bus.err_code[2]), 1);
        send_field(make_field(4'b0111, 12'd300, 1'b0, 6'd0, 1'b0), -1, 24);
        wait_done(lat);
        g_sym = int'(bus.n_sym);
        g_pad = int'(bus.n_pad);
        g_err = int'(bus.cfg_err);
        chk("c5_nsym_lit", g_sym, 34);
        send_field(make_field(4'b0111, 12'd300, 1'b0, 6'd0, 1'b0), 12, 24);
        wait_done(lat);
        chk("c5_gap_n_sym", int'(bus.n_sym), g_sym);
        chk("c5_gap_n_pad", int'(bus.n_pad), g_pad);
        chk("c5_gap_err", int'(bus.cfg_err), g_err);

        // case 6: restart during CALC, then reset mid-SHIFT
        send_field(make_field(4'b0011, 12'd4095, 1'b0, 6'd0, 1'b0), -1, 24);
        repeat (20) tick();
        send_field(make_field(4'b1101, 12'd100, 1'b0, 6'd0, 1'b0), -1, 24);
        wait_done(lat);
        chk("c6_latency", lat, 36);
        chk("c6_n_sym", int'(bus.n_sym), 35);
        chk("c6_rate", int'(bus.rate), 13);

        send_field(make_field(4'b1111, 12'd77, 1'b0, 6'd0, 1'b0), -1, 10);
        armed = 1'b0;
        rst   = 1'b1;
        tick();
        chk("rst_mid_busy", int'(bus.busy), 0);
        chk("rst_mid_cfg_valid", int'(bus.cfg_valid), 0);
        chk("rst_mid_n_sym", int'(bus.n_sym), 0);
        chk("rst_mid_length", int'(bus.length), 0);
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
